// File: rtl/if_stage_pipe_pkg.sv
// Shared definitions for the instruction-fetch stage and its IF/ID pipeline register.
// The ID stage consumes the if_id_t bundle directly.
package if_stage_pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // A squashed slot carries a NOP so a stray decode of it is harmless.
    localparam if_id_t IF_ID_BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_stage_pipe_if.sv
// Control, instruction-memory and IF/ID bundle signals of the fetch stage.
// The slave modport is the fetch stage itself; master is the surrounding core.
interface if_stage_pipe_if #(
    parameter int CNT_W = 16
);

    logic             stall_i;
    logic             branch_taken_i;
    logic [31:0]      branch_target_i;
    logic             jump_i;
    logic [31:0]      jump_target_i;
    logic [31:0]      instr_i;
    logic [31:0]      pc_o;
    logic [31:0]      if_id_pc4_o;
    logic [31:0]      if_id_instr_o;
    logic             if_id_valid_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, instr_i,
        output pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i, instr_i,
        input  pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/if_stage_pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// never reports a deceptively small count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_stage_pipe.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register, with stall/flush event counters for performance debug.
module if_stage_pipe
    import if_stage_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    if_stage_pipe_if.slave    bus
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    if_id_t      if_id;
    if_id_t      if_id_next;
    logic        stall_event;
    logic        flush_event;

    // Stall outranks redirects: the hazard unit re-presents the branch or jump
    // once the stall clears, so acting on it now would double-redirect.
    always_comb begin
        pc_next     = pc_plus4(pc);
        if_id_next  = '{pc4: pc_plus4(pc), instr: bus.instr_i, valid: 1'b1};
        stall_event = 1'b0;
        flush_event = 1'b0;
        if (bus.stall_i) begin
            pc_next     = pc;
            if_id_next  = if_id;
            stall_event = 1'b1;
        end else if (bus.branch_taken_i) begin
            pc_next     = bus.branch_target_i;
            if_id_next  = IF_ID_BUBBLE;
            flush_event = 1'b1;
        end else if (bus.jump_i) begin
            pc_next     = bus.jump_target_i;
            if_id_next  = IF_ID_BUBBLE;
            flush_event = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc    <= RESET_PC;
            if_id <= IF_ID_BUBBLE;
        end else begin
            pc    <= pc_next;
            if_id <= if_id_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (stall_event),
        .count (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (flush_event),
        .count (bus.flush_cnt_o)
    );

    assign bus.pc_o          = pc;
    assign bus.if_id_pc4_o   = if_id.pc4;
    assign bus.if_id_instr_o = if_id.instr;
    assign bus.if_id_valid_o = if_id.valid;

endmodule
